// File: rtl/vga_timing_generator_if.sv
// Pixel-side bundle between the VGA timing generator and the display blocks / VGA pins.
// master = timing generator, slave = display/observer side.
interface vga_timing_generator_if;
  logic [9:0] o_H_Counter;
  logic [9:0] o_V_Counter;
  logic       o_Frame_Start;
  logic [8:0] i_VGA_Pixel;
  logic       o_VGA_HSync;
  logic       o_VGA_VSync;
  logic [2:0] o_VGA_Red;
  logic [2:0] o_VGA_Grn;
  logic [2:0] o_VGA_Blu;

  modport master (
    output o_H_Counter, o_V_Counter, o_Frame_Start,
    output o_VGA_HSync, o_VGA_VSync, o_VGA_Red, o_VGA_Grn, o_VGA_Blu,
    input  i_VGA_Pixel
  );

  modport slave (
    input  o_H_Counter, o_V_Counter, o_Frame_Start,
    input  o_VGA_HSync, o_VGA_VSync, o_VGA_Red, o_VGA_Grn, o_VGA_Blu,
    output i_VGA_Pixel
  );
endinterface

// File: rtl/vga_timing_generator.sv
// VGA timing generator: free-running H/V counters, sync/blank delay line aligned to the returned pixel.
// Optional macro TEST_PATTERN_EN replaces the incoming pixel with eight 80-column colour bars.
module vga_timing_generator #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2,
  parameter int PIXEL_LATENCY = 2
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  vga_timing_generator_if.master vga
);

  localparam logic [9:0]  H_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0]  V_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [10:0] H_ACT  = 11'(ACTIVE_COLS);
  localparam logic [10:0] V_ACT  = 11'(ACTIVE_ROWS);
  localparam logic [10:0] HS_BEG = 11'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [10:0] HS_END = 11'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [10:0] VS_BEG = 11'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [10:0] VS_END = 11'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

  // Control word layout: {hsync, vsync, active[, bar index]}
`ifdef TEST_PATTERN_EN
  localparam int CW = 6;
`else
  localparam int CW = 3;
`endif
  localparam logic [CW-1:0] CTRL_IDLE = {2'b11, {(CW-2){1'b0}}};

  if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) begin : g_bad_h
    $error("vga_timing_generator: horizontal active+porch+sync exceeds TOTAL_COLS");
  end
  if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) begin : g_bad_v
    $error("vga_timing_generator: vertical active+porch+sync exceeds TOTAL_ROWS");
  end
  if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024) begin : g_bad_total
    $error("vga_timing_generator: TOTAL_COLS/TOTAL_ROWS must not exceed 1024");
  end
  if (PIXEL_LATENCY < 0 || PIXEL_LATENCY > 7) begin : g_bad_lat
    $error("vga_timing_generator: PIXEL_LATENCY must be in 0..7");
  end

`ifdef TEST_PATTERN_EN
  function automatic logic [2:0] bar_index(input logic [9:0] h);
    logic [2:0] k;
    k = '0;
    for (int i = 1; i < 8; i++) begin
      if (h >= 10'(80 * i)) k = 3'(i);
    end
    return k;
  endfunction
`endif

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       fs_q, fs_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
    fs_d = (h_d == '0) && (v_d == '0);
  end

  // fs_q resets high because the counters reset to the origin; the pin is held low while in reset.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      h_q  <= '0;
      v_q  <= '0;
      fs_q <= 1'b1;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      fs_q <= fs_d;
    end
  end

  logic hs_raw, vs_raw, active_raw;

  always_comb begin
    hs_raw     = !(({1'b0, h_q} >= HS_BEG) && ({1'b0, h_q} < HS_END));
    vs_raw     = !(({1'b0, v_q} >= VS_BEG) && ({1'b0, v_q} < VS_END));
    active_raw = ({1'b0, h_q} < H_ACT) && ({1'b0, v_q} < V_ACT);
  end

  logic [CW-1:0] ctrl_raw;
  logic [CW-1:0] ctrl_dly;

`ifdef TEST_PATTERN_EN
  assign ctrl_raw = {hs_raw, vs_raw, active_raw, bar_index(h_q)};
`else
  assign ctrl_raw = {hs_raw, vs_raw, active_raw};
`endif

  // Delay line matching the display blocks' pixel latency
  if (PIXEL_LATENCY == 0) begin : g_no_dly
    assign ctrl_dly = ctrl_raw;
  end else begin : g_dly
    logic [CW-1:0] dly_q [PIXEL_LATENCY];

    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
        for (int i = 0; i < PIXEL_LATENCY; i++) dly_q[i] <= CTRL_IDLE;
      end else begin
        dly_q[0] <= ctrl_raw;
        for (int i = 1; i < PIXEL_LATENCY; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign ctrl_dly = dly_q[PIXEL_LATENCY-1];
  end

  logic [8:0] pix_src;
  logic [8:0] rgb_d, rgb_q;
  logic       hs_q, vs_q;

`ifdef TEST_PATTERN_EN
  assign pix_src = {{3{ctrl_dly[2]}}, {3{ctrl_dly[1]}}, {3{ctrl_dly[0]}}};
`else
  assign pix_src = vga.i_VGA_Pixel;
`endif

  assign rgb_d = ctrl_dly[CW-3] ? pix_src : 9'd0;

  // Output register onto the pins
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= '0;
    end else begin
      hs_q  <= ctrl_dly[CW-1];
      vs_q  <= ctrl_dly[CW-2];
      rgb_q <= rgb_d;
    end
  end

  assign vga.o_H_Counter   = h_q;
  assign vga.o_V_Counter   = v_q;
  assign vga.o_Frame_Start = fs_q & ~i_Rst;
  assign vga.o_VGA_HSync   = hs_q;
  assign vga.o_VGA_VSync   = vs_q;
  assign vga.o_VGA_Red     = rgb_q[8:6];
  assign vga.o_VGA_Grn     = rgb_q[5:3];
  assign vga.o_VGA_Blu     = rgb_q[2:0];

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Generates the free-running horizontal/vertical counters consumed by the background and sprite display blocks.
- Accepts their 9-bit pixel back after a fixed pipeline latency.
- Drives the VGA pins: HSync, VSync and 3-bit R/G/B, with syncs and blanking delayed to line up with the returned pixel.
- Sits at the top level, between the display blocks and the board VGA connector.

Parameters:
TOTAL_COLS, 800, pixel clocks per line
TOTAL_ROWS, 525, lines per frame
ACTIVE_COLS, 640, visible pixels per line
ACTIVE_ROWS, 480, visible lines per frame
H_FRONT_PORCH, 16, pixel clocks from end of active line to HSync assertion
H_SYNC_WIDTH, 96, HSync low width in pixel clocks
V_FRONT_PORCH, 10, lines from end of active frame to VSync assertion
V_SYNC_WIDTH, 2, VSync low width in lines
PIXEL_LATENCY, 2, cycles from counters showing (h,v) to i_VGA_Pixel carrying pixel (h,v); legal range 0..7

Ports:
i_Clk  input  1  pixel clock (25.175 MHz nominal); single clock domain
i_Rst  input  1  asynchronous, active-high reset
o_H_Counter  output  10  current column, 0..TOTAL_COLS-1
o_V_Counter  output  10  current line, 0..TOTAL_ROWS-1
o_Frame_Start  output  1  one-cycle pulse when counters equal (0,0)
i_VGA_Pixel  input  9  pixel from display blocks; [8:6] red, [5:3] green, [2:0] blue
o_VGA_HSync  output  1  horizontal sync, active low
o_VGA_VSync  output  1  vertical sync, active low
o_VGA_Red  output  3  red
o_VGA_Grn  output  3  green
o_VGA_Blu  output  3  blue

Behaviour:
- Reset (async, active-high, no clock edge required):
  - counters = 0; o_Frame_Start = 0.
  - o_VGA_HSync = 1, o_VGA_VSync = 1; RGB = 0.
  - All delay-line stages cleared to "sync inactive, blanked".
- Counters, all registered:
  - H increments every cycle; at TOTAL_COLS-1 it wraps to 0.
  - V increments only on an H wrap; at TOTAL_ROWS-1 together with an H wrap it wraps to 0.
- o_Frame_Start: registered; high exactly in cycles where o_H_Counter==0 && o_V_Counter==0 and reset is deasserted. This includes the first cycle after reset release.
- Raw timing decode from the current counters:
  - hs_raw low iff ACTIVE_COLS+H_FRONT_PORCH <= H < ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH.
  - vs_raw low iff ACTIVE_ROWS+V_FRONT_PORCH <= V < ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH. VSync changes only when H==0.
  - active_raw = (H < ACTIVE_COLS) && (V < ACTIVE_ROWS).
- Alignment:
  - hs_raw, vs_raw and active_raw pass through a shift register PIXEL_LATENCY stages deep, so they line up with i_VGA_Pixel.
  - The delayed values and the pixel are then registered once more onto the pins.
  - Pins reflect position (h,v) exactly PIXEL_LATENCY+1 cycles after the counters showed (h,v).
  - PIXEL_LATENCY=0 means no delay stages, only the output register.
- RGB:
  - If delayed active: R=i_VGA_Pixel[8:6], G=[5:3], B=[2:0].
  - Otherwise RGB = 0, regardless of i_VGA_Pixel content.
- Reset mid-frame: everything returns to reset values immediately. After release, counting restarts from (0,0) with no partial-frame recovery. The delay lines start blanked, so no stale pixel reaches the pins.
- Parameter legality:
  - ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH <= TOTAL_COLS.
  - The same rule applies vertically.
  - TOTAL_COLS and TOTAL_ROWS <= 1024.
  - An illegal combination produces a simulation-time $error; no runtime checking.

Optional Feature:
- Macro TEST_PATTERN_EN.
- Defined: i_VGA_Pixel is ignored.
  - Pixel for column H is colour bar k = H/80, for k in 0..7.
  - Pattern pixel = {{3{k[2]}},{3{k[1]}},{3{k[0]}}}.
  - k is derived from the undelayed counter and passed through the same PIXEL_LATENCY delay, so bar edges align with the sync timing.
  - Blanking rules are unchanged.
- Undefined: pure passthrough as above; no bar logic is synthesised.

Test Plan:
1. Release reset with defaults -> o_Frame_Start=1 in first cycle with counters (0,0); H reaches 799 at cycle 799 and reads 0 at cycle 800 with V=1; V=524,H=799 is followed by (0,0) with o_Frame_Start=1.
2. Observe HSync with PIXEL_LATENCY=2 -> o_VGA_HSync falls 3 cycles after o_H_Counter==656 and stays low exactly 96 cycles; no HSync glitch at the V wrap.
3. Observe VSync -> o_VGA_VSync falls 3 cycles after (H=0,V=490) and stays low exactly 1600 cycles; o_Frame_Start period is exactly 420000 cycles.
4. Drive i_VGA_Pixel=9'b111_000_101 constantly -> inside delayed-active region R=7,G=0,B=5; for positions H=640..799 or V>=480 (as seen at the pins) RGB=0.
5. Assert i_Rst asynchronously at H=300,V=200 between clock edges -> RGB=0 and syncs=1 before the next edge; after release, counters restart at (0,0) and the first 3 pin cycles are blanked.
6. Rebuild with TEST_PATTERN_EN, i_VGA_Pixel=0 -> pixel at H=0..79 is 0x000, H=80 gives B=7 only, H=560..639 gives R=G=B=7, each transition appearing 3 cycles after the counter transition.
